sensor_block_buffer: RTL and testbench

Per-sensor capture buffer that sits between a sensor's block decoder and the pulse identification logic; one instance per photodiode channel (8 total).
Stores each 41-bit decoded block in write order and reports how many blocks are available.
Serves random-access read requests by 1-based block number with a registered data/ready handshake.
Self-clears ("RAM dump") after the sensor goes quiet and the consumer has released its request, which is what drives the consumer's avl_blocks_nb-to-zero reset detection.

---
 rtl/sensor_block_buffer.sv | 158 +++++++++++++++
 tb/tb_sensor_block_buffer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sensor_block_buffer.sv
// Per-channel capture buffer for decoded sensor blocks with 1-based random-access reads and self-clear.
// Optional build macro BLOCK_BUFFER_OVERFLOW_CNT_EN adds a saturating dropped-block counter output.
//
// state      | meaning
// S_EMPTY    | nothing stored, waiting for the first block
// S_FILLING  | storing blocks, silence counter running
// S_COMPLETE | sensor quiet, contents frozen until the consumer releases
// S_DUMP     | one-cycle clear of count and flags
module sensor_block_buffer #(
   parameter int DEPTH         = 128,
   parameter int SILENCE_TICKS = 72000
) (
   input  logic        clk_72MHz,
   input  logic        reset,
   input  logic [40:0] block_in,
   input  logic        block_in_valid,
   input  logic [7:0]  block_wanted_number,
   output logic [40:0] block_wanted,
   output logic        data_ready,
   output logic [7:0]  avl_blocks_nb,
   output logic        overflow
`ifdef BLOCK_BUFFER_OVERFLOW_CNT_EN
   ,
   output logic [7:0]  overflow_count
`endif
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int SW = (SILENCE_TICKS > 1) ? $clog2(SILENCE_TICKS) : 1;
   localparam logic [SW-1:0] SIL_LAST = SW'(SILENCE_TICKS - 1);
   localparam logic [7:0]    DEPTH_NB = 8'(DEPTH);

   typedef enum logic [1:0] {S_EMPTY, S_FILLING, S_COMPLETE, S_DUMP} state_t;

   state_t        state_q, state_d;
   logic [7:0]    count_q, count_d;
   logic [SW-1:0] sil_q, sil_d;
   logic [7:0]    req_q;
   logic          in_range_q, in_range_d;
   logic [40:0]   blk_q, blk_d;
   logic          rdy_q, rdy_d;
   logic          ovf_q, ovf_d;
   logic          wr_en;
   logic [AW-1:0] wr_idx, rd_idx;
   logic [40:0]   ram_q [DEPTH];

   assign wr_idx = count_q[AW-1:0];
   assign rd_idx = AW'(req_q - 8'd1);

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      sil_d   = sil_q;
      ovf_d   = ovf_q;
      wr_en   = 1'b0;
      case (state_q)
         S_EMPTY: begin
            if (block_in_valid) begin
               wr_en   = 1'b1;
               count_d = 8'd1;
               sil_d   = '0;
               state_d = S_FILLING;
            end
         end
         S_FILLING: begin
            if (block_in_valid) begin
               sil_d = '0;
               if (count_q == DEPTH_NB) begin
                  ovf_d = 1'b1;
               end else begin
                  wr_en   = 1'b1;
                  count_d = count_q + 8'd1;
               end
            end else if (sil_q != '1) begin
               sil_d = sil_q + 1'b1;
            end
            if (sil_d == SIL_LAST) state_d = S_COMPLETE;
         end
         S_COMPLETE: begin
            // req_q holds last cycle's request, so both zero means two quiet cycles
            if (block_wanted_number == 8'd0 && req_q == 8'd0) begin
               state_d = S_DUMP;
               count_d = 8'd0;
               ovf_d   = 1'b0;
               sil_d   = '0;
            end
         end
         default: state_d = S_EMPTY;
      endcase
   end

   // Range is judged against the count one cycle early so a pending request
   // is served two cycles after the count reaches it, same as a fresh one.
   always_comb begin
      in_range_d = (block_wanted_number != 8'd0) && (block_wanted_number <= count_q);
      rdy_d      = 1'b0;
      blk_d      = blk_q;
      if (state_d == S_DUMP) begin
         in_range_d = 1'b0;
         blk_d      = '0;
      end else if (state_q != S_DUMP && in_range_q && block_wanted_number == req_q) begin
         rdy_d = 1'b1;
         blk_d = (wr_en && wr_idx == rd_idx) ? block_in : ram_q[rd_idx];
      end
   end

   always_ff @(posedge clk_72MHz) begin
      if (wr_en && !reset) ram_q[wr_idx] <= block_in;
   end

   always_ff @(posedge clk_72MHz) begin
      if (reset) begin
         state_q    <= S_EMPTY;
         count_q    <= 8'd0;
         sil_q      <= '0;
         req_q      <= 8'd0;
         in_range_q <= 1'b0;
         blk_q      <= '0;
         rdy_q      <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         sil_q      <= sil_d;
         req_q      <= block_wanted_number;
         in_range_q <= in_range_d;
         blk_q      <= blk_d;
         rdy_q      <= rdy_d;
         ovf_q      <= ovf_d;
      end
   end

   assign block_wanted  = blk_q;
   assign data_ready    = rdy_q;
   assign avl_blocks_nb = count_q;
   assign overflow      = ovf_q;

`ifdef BLOCK_BUFFER_OVERFLOW_CNT_EN
   logic [7:0] ovf_cnt_q, ovf_cnt_d;
   logic       ovf_drop;

   assign ovf_drop = (state_q == S_FILLING) && block_in_valid && (count_q == DEPTH_NB);

   always_comb begin
      ovf_cnt_d = ovf_cnt_q;
      if (state_d == S_DUMP) ovf_cnt_d = 8'd0;
      else if (ovf_drop && ovf_cnt_q != 8'hFF) ovf_cnt_d = ovf_cnt_q + 8'd1;
   end

   always_ff @(posedge clk_72MHz) begin
      if (reset) ovf_cnt_q <= 8'd0;
      else       ovf_cnt_q <= ovf_cnt_d;
   end

   assign overflow_count = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_sensor_block_buffer.sv
// Directed bench for sensor_block_buffer with DEPTH=6 and SILENCE_TICKS=100.
module tb_sensor_block_buffer;

   logic        clk_72MHz;
   logic        reset;
   logic [40:0] block_in;
   logic        block_in_valid;
   logic [7:0]  block_wanted_number;
   logic [40:0] block_wanted;
   logic        data_ready;
   logic [7:0]  avl_blocks_nb;
   logic        overflow;
`ifdef BLOCK_BUFFER_OVERFLOW_CNT_EN
   logic [7:0]  overflow_count;
`endif

   int n_cmp = 0;
   int n_err = 0;

   sensor_block_buffer #(.DEPTH(6), .SILENCE_TICKS(100)) dut (
      .clk_72MHz           (clk_72MHz),
      .reset               (reset),
      .block_in            (block_in),
      .block_in_valid      (block_in_valid),
      .block_wanted_number (block_wanted_number),
      .block_wanted        (block_wanted),
      .data_ready          (data_ready),
      .avl_blocks_nb       (avl_blocks_nb),
      .overflow            (overflow)
`ifdef BLOCK_BUFFER_OVERFLOW_CNT_EN
      ,
      .overflow_count      (overflow_count)
`endif
   );

   initial clk_72MHz = 1'b0;
   always #5 clk_72MHz = ~clk_72MHz;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_72MHz);
      #1;
   endtask

   task automatic send(input logic [40:0] data);
      block_in       = data;
      block_in_valid = 1'b1;
      step();
      block_in_valid = 1'b0;
   endtask

   initial begin
      reset               = 1'b1;
      block_in            = '0;
      block_in_valid      = 1'b0;
      block_wanted_number = 8'd0;
      step();
      step();
      reset = 1'b0;
      chk("rst_avl", avl_blocks_nb, 0);
      chk("rst_rdy", data_ready, 0);
      chk("rst_blk", block_wanted, 0);
      chk("rst_ovf", overflow, 0);

      for (int i = 1; i <= 3; i++) begin
         send(41'h1_0000_0000 + 41'(i));
         chk($sformatf("avl_after_wr%0d", i), avl_blocks_nb, 64'(i));
         repeat (9) step();
      end
      chk("ovf_after_3", overflow, 0);

      block_wanted_number = 8'd2;
      step();
      chk("rd2_rdy_c1", data_ready, 0);
      step();
      chk("rd2_rdy_c2", data_ready, 1);
      chk("rd2_blk", block_wanted, 41'h1_0000_0002);
      step();
      chk("rd2_hold", data_ready, 1);
      block_wanted_number = 8'd3;
      step();
      chk("rd3_rdy_c1", data_ready, 0);
      chk("rd3_blk_held", block_wanted, 41'h1_0000_0002);
      step();
      chk("rd3_rdy_c2", data_ready, 1);
      chk("rd3_blk", block_wanted, 41'h1_0000_0003);

      block_wanted_number = 8'd5;
      step();
      step();
      chk("rd5_pend_rdy", data_ready, 0);
      chk("rd5_pend_blk", block_wanted, 41'h1_0000_0003);
      send(41'h1_0000_0004);
      chk("avl_4", avl_blocks_nb, 4);
      step();
      chk("rd5_still_pend", data_ready, 0);
      repeat (97) step();
      send(41'h1_0000_0005);
      chk("avl_5_after_98_quiet", avl_blocks_nb, 5);
      step();
      chk("rd5_svc_c1", data_ready, 0);
      step();
      chk("rd5_svc_c2", data_ready, 1);
      chk("rd5_blk", block_wanted, 41'h1_0000_0005);

      repeat (97) step();
      send(41'h1_0000_0009);
      chk("complete_ignores", avl_blocks_nb, 5);
      chk("complete_rdy", data_ready, 1);
      chk("complete_blk", block_wanted, 41'h1_0000_0005);
      repeat (3) step();
      chk("no_dump_held", avl_blocks_nb, 5);
      block_wanted_number = 8'd0;
      step();
      chk("rel1_avl", avl_blocks_nb, 5);
      chk("rel1_rdy", data_ready, 0);
      chk("rel1_blk_held", block_wanted, 41'h1_0000_0005);
      step();
      chk("dump_avl", avl_blocks_nb, 0);
      chk("dump_blk", block_wanted, 0);
      chk("dump_ovf", overflow, 0);
      step();
      step();

      for (int i = 1; i <= 6; i++) send(41'h2_0000_0000 + 41'(i));
      chk("full_avl", avl_blocks_nb, 6);
      chk("full_ovf0", overflow, 0);
      send(41'h2_0000_00FF);
      chk("ovf_avl", avl_blocks_nb, 6);
      chk("ovf_flag", overflow, 1);
`ifdef BLOCK_BUFFER_OVERFLOW_CNT_EN
      chk("ovf_cnt1", overflow_count, 1);
`endif
      block_wanted_number = 8'd6;
      step();
      step();
      chk("rd6_rdy", data_ready, 1);
      chk("rd6_blk", block_wanted, 41'h2_0000_0006);
      repeat (100) step();
      chk("ovf_sticky", overflow, 1);
      block_wanted_number = 8'd0;
      step();
      step();
      chk("dump2_avl", avl_blocks_nb, 0);
      chk("dump2_ovf", overflow, 0);
`ifdef BLOCK_BUFFER_OVERFLOW_CNT_EN
      chk("dump2_cnt", overflow_count, 0);
`endif
      step();
      step();

      send(41'h3_0000_0001);
      chk("c_avl1", avl_blocks_nb, 1);
      block_wanted_number = 8'd1;
      step();
      step();
      chk("c_rdy", data_ready, 1);
      chk("c_blk", block_wanted, 41'h3_0000_0001);
      block_in       = 41'h3_0000_0002;
      block_in_valid = 1'b1;
      reset          = 1'b1;
      step();
      reset          = 1'b0;
      block_in_valid = 1'b0;
      chk("rstwr_avl", avl_blocks_nb, 0);
      chk("rstwr_rdy", data_ready, 0);
      chk("rstwr_blk", block_wanted, 0);
      send(41'h3_0000_0003);
      chk("post_rst_avl", avl_blocks_nb, 1);
      step();
      step();
      chk("post_rst_rdy", data_ready, 1);
      chk("post_rst_blk", block_wanted, 41'h3_0000_0003);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
